// File: rtl/inst_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// Holds the format codes, the field widths, the common opcodes and, when
// INST_ENCODER_IMM_CHECK_EN is defined, the immediate range check.
package inst_enc_pkg;

  localparam int unsigned INST_W   = 32;
  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned FUNCT3_W = 3;
  localparam int unsigned FUNCT7_W = 7;
  localparam int unsigned IMM_W    = 32;
  localparam int unsigned FMT_W    = 3;

  // Format codes; 6 and 7 are illegal and produce a flagged zero word.
  typedef enum logic [FMT_W-1:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [OPCODE_W-1:0] OP_REG    = 7'h33;
  localparam logic [OPCODE_W-1:0] OP_IMM    = 7'h13;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'h23;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'h63;
  localparam logic [OPCODE_W-1:0] OP_LUI    = 7'h37;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'h6F;

`ifdef INST_ENCODER_IMM_CHECK_EN
  // True when imm cannot be carried exactly by the given format.
  // A signed N-bit value has bits [31:N-1] all equal.
  function automatic logic imm_unrepresentable(input logic [FMT_W-1:0] fmt,
                                               input logic [IMM_W-1:0] imm);
    logic bad;
    bad = 1'b0;
    case (fmt)
      FMT_I, FMT_S: bad = !((&imm[31:11]) || !(|imm[31:11]));
      FMT_B:        bad = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      FMT_J:        bad = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      FMT_U:        bad = |imm[11:0];
      default:      bad = 1'b0;
    endcase
    return bad;
  endfunction
`endif

endpackage

// File: rtl/inst_encoder_if.sv
// Field-bundle input and encoded-word output bus of inst_encoder.
// slave: encoder side (consumes fields, produces words).
// master: source/sink side (drives fields and out_ready).
// imm_err exists only when INST_ENCODER_IMM_CHECK_EN is defined.
interface inst_encoder_if #(
  parameter int unsigned ADDR_W = 32
);
  import inst_enc_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [FMT_W-1:0]    fmt;
  logic [OPCODE_W-1:0] opcode;
  logic [REG_W-1:0]    rd;
  logic [FUNCT3_W-1:0] funct3;
  logic [REG_W-1:0]    rs1;
  logic [REG_W-1:0]    rs2;
  logic [FUNCT7_W-1:0] funct7;
  logic [IMM_W-1:0]    imm;
  logic                out_valid;
  logic                out_ready;
  logic [INST_W-1:0]   inst;
  logic [ADDR_W-1:0]   addr;
  logic                fmt_err;
`ifdef INST_ENCODER_IMM_CHECK_EN
  logic                imm_err;
`endif

  modport slave (
    input  in_valid, fmt, opcode, rd, funct3, rs1, rs2, funct7, imm, out_ready,
    output in_ready, out_valid, inst, addr, fmt_err
`ifdef INST_ENCODER_IMM_CHECK_EN
    , output imm_err
`endif
  );

  modport master (
    output in_valid, fmt, opcode, rd, funct3, rs1, rs2, funct7, imm, out_ready,
    input  in_ready, out_valid, inst, addr, fmt_err
`ifdef INST_ENCODER_IMM_CHECK_EN
    , input imm_err
`endif
  );

endinterface

// File: rtl/inst_enc_fifo.sv
// Generic 2-entry valid/ready FIFO.
// Ports: clk, reset (sync, active-high), push_valid/push_ready/push_data,
// pop_valid/pop_ready/pop_data. While empty, pop_data keeps showing the last
// popped entry (RST_VAL after reset).
module inst_enc_fifo #(
  parameter int unsigned W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  logic [W-1:0] mem_q [2];
  logic [1:0]   cnt_q;
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic         push;
  logic         pop;
  logic         head_idx;

  // A pop on the same edge frees the slot the push lands in.
  assign push_ready = (cnt_q != 2'd2) || pop_ready;
  assign pop_valid  = (cnt_q != 2'd0);
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;

  // When empty the last popped entry sits behind rd_ptr and is untouched
  // until the next push, which writes at rd_ptr.
  assign head_idx = (cnt_q == 2'd0) ? ~rd_ptr_q : rd_ptr_q;
  assign pop_data = mem_q[head_idx];

  // Storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= RST_VAL;
      cnt_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs one field bundle per handshake into a
// 32-bit word, tags it with a sequential byte address and queues it in a
// 2-entry FIFO.
// Ports: clk, reset (sync, active-high), bus (inst_encoder_if.slave) with the
// field bundle, in_valid/in_ready, out_valid/out_ready, inst, addr, fmt_err.
// Optional macro INST_ENCODER_IMM_CHECK_EN adds bus.imm_err.
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic          clk,
  input  logic          reset,
  inst_encoder_if.slave bus
);

`ifdef INST_ENCODER_IMM_CHECK_EN
  localparam int unsigned PAY_W = 2 + ADDR_W + INST_W;
  localparam logic [PAY_W-1:0] PAY_RST = {1'b0, 1'b0, BASE_ADDR, INST_W'(0)};
`else
  localparam int unsigned PAY_W = 1 + ADDR_W + INST_W;
  localparam logic [PAY_W-1:0] PAY_RST = {1'b0, BASE_ADDR, INST_W'(0)};
`endif

  logic [INST_W-1:0] enc_c;
  logic              fmt_err_c;
  logic [ADDR_W-1:0] addr_q;
  logic [PAY_W-1:0]  push_data;
  logic [PAY_W-1:0]  pop_data;

  // Field packing per format; illegal formats yield a flagged zero word
  always_comb begin
    enc_c     = '0;
    fmt_err_c = 1'b0;
    case (bus.fmt)
      FMT_R: enc_c = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
      FMT_I: enc_c = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
      FMT_S: enc_c = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0],
                      bus.opcode};
      FMT_B: enc_c = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                      bus.imm[4:1], bus.imm[11], bus.opcode};
      FMT_U: enc_c = {bus.imm[31:12], bus.rd, bus.opcode};
      FMT_J: enc_c = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                      bus.rd, bus.opcode};
      default: fmt_err_c = 1'b1;
    endcase
  end

`ifdef INST_ENCODER_IMM_CHECK_EN
  assign push_data = {fmt_err_c, imm_unrepresentable(bus.fmt, bus.imm), addr_q, enc_c};
  assign bus.imm_err = pop_data[INST_W+ADDR_W];
`else
  assign push_data = {fmt_err_c, addr_q, enc_c};
`endif

  assign bus.inst    = pop_data[INST_W-1:0];
  assign bus.addr    = pop_data[INST_W +: ADDR_W];
  assign bus.fmt_err = pop_data[PAY_W-1];

  // Address tag counter; wraps silently
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= BASE_ADDR;
    end else if (bus.in_valid && bus.in_ready) begin
      addr_q <= addr_q + ADDR_W'(4);
    end
  end

  inst_enc_fifo #(
    .W       (PAY_W),
    .RST_VAL (PAY_RST)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_valid (bus.in_valid),
    .push_ready (bus.in_ready),
    .push_data  (push_data),
    .pop_valid  (bus.out_valid),
    .pop_ready  (bus.out_ready),
    .pop_data   (pop_data)
  );

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder. BASE_ADDR sits just below
// the 32-bit wrap so address sequences also cross zero.
module tb_inst_encoder;

  localparam logic [31:0] BASE = 32'hFFFF_FFF8;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_inst;
    logic        exp_ferr;
    logic        exp_ierr;
    logic        rt;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [31:0] addr;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t exp_q[$];
  logic [31:0] exp_addr;

  inst_encoder_if #(.ADDR_W(32)) bus ();

  inst_encoder #(.ADDR_W(32), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] fmt, input logic [6:0] op,
                              input logic [4:0] rd, input logic [2:0] f3,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [6:0] f7, input logic [31:0] imm,
                              input logic [31:0] exp_inst, input logic exp_ferr,
                              input logic exp_ierr, input logic rt);
    vec_t v;
    v.fmt = fmt; v.op = op; v.rd = rd; v.f3 = f3; v.rs1 = rs1; v.rs2 = rs2;
    v.f7 = f7; v.imm = imm; v.exp_inst = exp_inst; v.exp_ferr = exp_ferr;
    v.exp_ierr = exp_ierr; v.rt = rt;
    return v;
  endfunction

  // Independent field decoder used for round-trip checks of the immediate
  function automatic logic [31:0] dec_imm(input logic [2:0] fmt, input logic [31:0] i);
    logic [31:0] r;
    case (fmt)
      3'd1:    r = {{20{i[31]}}, i[31:20]};
      3'd2:    r = {{20{i[31]}}, i[31:25], i[11:7]};
      3'd3:    r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd4:    r = {i[31:12], 12'b0};
      3'd5:    r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Word monitor: every transfer is compared with the next expected word
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 64'(bus.inst), 64'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("word_inst", 64'(bus.inst), 64'(e.v.exp_inst));
        check("word_addr", 64'(bus.addr), 64'(e.addr));
        check("word_fmt_err", 64'(bus.fmt_err), 64'(e.v.exp_ferr));
`ifdef INST_ENCODER_IMM_CHECK_EN
        check("word_imm_err", 64'(bus.imm_err), 64'(e.v.exp_ierr));
`endif
        if (e.v.rt) begin
          check("rt_imm", 64'(dec_imm(e.v.fmt, bus.inst)), 64'(e.v.imm));
          check("rt_opcode", 64'(bus.inst[6:0]), 64'(e.v.op));
        end
      end
    end
  end

  task automatic drive(input vec_t v);
    bus.fmt = v.fmt; bus.opcode = v.op; bus.rd = v.rd; bus.funct3 = v.f3;
    bus.rs1 = v.rs1; bus.rs2 = v.rs2; bus.funct7 = v.f7; bus.imm = v.imm;
    bus.in_valid = 1'b1;
  endtask

  task automatic record(input vec_t v);
    exp_t e;
    e.v = v;
    e.addr = exp_addr;
    exp_q.push_back(e);
    exp_addr = exp_addr + 32'd4;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
    end
    if (ok) @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic send(input vec_t v);
    bit ok;
    drive(v);
    wait_accept(ok);
    if (ok) record(v);
    else check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!bus.out_valid && exp_q.size() == 0) break;
    end
    check("drain_out_valid", 64'(bus.out_valid), 64'd0);
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    exp_addr = BASE;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v_add, v_addi, v_beq, v_jal, v_ones, v_sw, v_lui, v_bad6, v_bad7;
    vec_t v_ibig, v_ineg, v_b3, v_u1;
    bit ok;

    v_add  = mk(3'd0, 7'h33, 5'd3,  3'd0, 5'd1,  5'd2,  7'h00, 32'h0,         32'h002081B3, 1'b0, 1'b0, 1'b0);
    v_addi = mk(3'd1, 7'h13, 5'd5,  3'd0, 5'd0,  5'd0,  7'h00, 32'hFFFF_FFFF, 32'hFFF00293, 1'b0, 1'b0, 1'b1);
    v_beq  = mk(3'd3, 7'h63, 5'd0,  3'd0, 5'd1,  5'd2,  7'h00, 32'h8,         32'h00208463, 1'b0, 1'b0, 1'b1);
    v_jal  = mk(3'd5, 7'h6F, 5'd1,  3'd0, 5'd0,  5'd0,  7'h00, 32'h800,       32'h001000EF, 1'b0, 1'b0, 1'b1);
    v_ones = mk(3'd0, 7'h7F, 5'h1F, 3'h7, 5'h1F, 5'h1F, 7'h7F, 32'hFFFF_FFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    v_sw   = mk(3'd2, 7'h23, 5'd0,  3'd2, 5'd2,  5'd5,  7'h00, 32'hFFFF_FFEC, 32'hFE512623, 1'b0, 1'b0, 1'b1);
    v_lui  = mk(3'd4, 7'h37, 5'd7,  3'd0, 5'd0,  5'd0,  7'h00, 32'h1234_5000, 32'h123453B7, 1'b0, 1'b0, 1'b1);
    v_bad6 = mk(3'd6, 7'h33, 5'd3,  3'd0, 5'd1,  5'd2,  7'h00, 32'h0,         32'h00000000, 1'b1, 1'b0, 1'b0);
    v_bad7 = mk(3'd7, 7'h13, 5'd5,  3'd1, 5'd1,  5'd2,  7'h7F, 32'h7,         32'h00000000, 1'b1, 1'b0, 1'b0);
    v_ibig = mk(3'd1, 7'h13, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 32'h800,       32'h80000013, 1'b0, 1'b1, 1'b0);
    v_ineg = mk(3'd1, 7'h13, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 32'hFFFF_F800, 32'h80000013, 1'b0, 1'b0, 1'b1);
    v_b3   = mk(3'd3, 7'h63, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 32'h3,         32'h00000163, 1'b0, 1'b1, 1'b0);
    v_u1   = mk(3'd4, 7'h37, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 32'h1,         32'h00000037, 1'b0, 1'b1, 1'b0);

    checks = 0;
    errors = 0;
    exp_addr = BASE;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.fmt = '0; bus.opcode = '0; bus.rd = '0; bus.funct3 = '0;
    bus.rs1 = '0; bus.rs2 = '0; bus.funct7 = '0; bus.imm = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_inst", 64'(bus.inst), 64'd0);
    check("rst_addr", 64'(bus.addr), 64'(BASE));
    check("rst_fmt_err", 64'(bus.fmt_err), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Single word: one-cycle latency, then hold while empty
    bus.out_ready = 1'b1;
    send(v_add);
    @(negedge clk);
    check("lat_out_valid", 64'(bus.out_valid), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("empty_out_valid", 64'(bus.out_valid), 64'd0);
    check("hold_inst", 64'(bus.inst), 64'h002081B3);
    check("hold_addr", 64'(bus.addr), 64'(BASE));
    @(posedge clk);
    #1;

    // Back-to-back stream across all formats; addresses wrap through zero
    send(v_addi); send(v_beq); send(v_jal); send(v_ones); send(v_sw); send(v_lui);
    drain();

    // Backpressure: two accepted, third stalls, then push and pop together
    do_reset();
    bus.out_ready = 1'b0;
    send(v_add);
    send(v_sw);
    @(negedge clk);
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    check("full_out_valid", 64'(bus.out_valid), 64'd1);
    check("full_head_addr", 64'(bus.addr), 64'(BASE));
    @(posedge clk);
    #1;
    drive(v_lui);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("stall_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    check("pushpop_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    record(v_lui);
    @(negedge clk);
    check("pushpop_out_valid", 64'(bus.out_valid), 64'd1);
    check("pushpop_head_addr", 64'(bus.addr), 64'(BASE + 32'd4));
    @(posedge clk);
    #1;
    drain();

    // Reset with two words queued discards them and restarts the tag
    bus.out_ready = 1'b0;
    send(v_add);
    send(v_sw);
    do_reset();
    @(negedge clk);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    check("midrst_addr", 64'(bus.addr), 64'(BASE));
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    send(v_jal);
    drain();

    // Illegal formats still consume addresses; immediate range cases
    send(v_bad6); send(v_add); send(v_bad7); send(v_ibig);
    send(v_ineg); send(v_b3); send(v_u1); send(v_ones);
    drain();

    // Bounded stall check: a held bundle is not accepted while full
    do_reset();
    bus.out_ready = 1'b0;
    send(v_beq);
    send(v_beq);
    drive(v_addi);
    wait_accept(ok);
    check("full_never_accepts", 64'(ok), 64'd0);
    bus.out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Builds 32-bit RV32I instruction words from separate fields. It is the inverse of the instruction-field decoder.
- Accepts one field bundle per valid/ready handshake and packs it per the selected format (R/I/S/B/U/J).
- Buffers results in a 2-entry output FIFO. Each word is tagged with a sequential byte address for instruction-memory loaders and decoder round-trip benches.

Parameters:
- ADDR_W, 32, width of the address tag.
- BASE_ADDR, 32'h0000_0000, address tagged on the first word after reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- fmt  in  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- opcode  in  7  opcode field, inst[6:0].
- rd  in  5  destination register.
- funct3  in  3  funct3 field.
- rs1  in  5  source register 1.
- rs2  in  5  source register 2.
- funct7  in  7  funct7 field (R format only).
- imm  in  32  immediate, sign-extended full value.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  downstream accepts the word.
- inst  out  32  encoded instruction.
- addr  out  ADDR_W  byte address tag of inst.
- fmt_err  out  1  the word was produced from an illegal fmt.

Behaviour:
- Reset (synchronous, held one or more edges):
  - FIFO emptied; out_valid=0, inst=0, addr=BASE_ADDR, fmt_err=0.
  - Address counter = BASE_ADDR; in_ready=1 from the first cycle after reset deasserts.
  - Reset mid-operation discards buffered words. No partial handshake completes on a reset edge.
- Handshakes:
  - Input transfer on an edge with in_valid && in_ready.
  - Output transfer on an edge with out_valid && out_ready.
  - in_ready = (FIFO count < 2), or count==2 with out_ready=1 (a pop this edge frees a slot).
- Latency: a bundle accepted at edge N is presented at the FIFO head after edge N when the FIFO was empty, so out_valid=1 in cycle N+1. No combinational path from inputs to inst.
- Encoding (combinational from fields, then registered into the FIFO):
  - R: funct7|rs2|rs1|funct3|rd|opcode.
  - I: imm[11:0]|rs1|funct3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
  - Illegal fmt (6, 7): inst=32'h0000_0000 and fmt_err=1; the word is still enqueued and consumes an address.
- Address tagging:
  - The tag is assigned at enqueue from the counter; the counter += 4 per accepted input.
  - Wraps modulo 2^ADDR_W with no flag.
- FIFO: 2 entries, pointers plus count, order preserved.
  - Simultaneous push and pop: allowed at any count, count unchanged.
  - Full with no pop: input stalls; fields must be held by the source.
  - Empty: out_valid=0; inst/addr/fmt_err hold their last value.

Optional Feature:
- Macro INST_ENCODER_IMM_CHECK_EN.
- When defined: adds output port imm_err (1 bit), queued with the word. It is set when imm is not representable in the format:
  - I/S: signed 12-bit range.
  - B: signed 13-bit range with imm[0]=0.
  - J: signed 21-bit range with imm[0]=0.
  - U: imm[11:0]!=0.
  - R: never set.
- When defined, encoding is otherwise unchanged (truncating).
- When undefined: no imm_err port; no check logic.

Decomposition:
- Package inst_enc_pkg:
  - fmt codes (FMT_R..FMT_J) as a 3-bit enum.
  - Field widths.
  - Common opcode constants (OP_REG 7'h33, OP_IMM 7'h13, OP_STORE 7'h23, OP_BRANCH 7'h63, OP_LUI 7'h37, OP_JAL 7'h6F).
- One sub-module, inst_enc_fifo: a generic 2-entry valid/ready FIFO carrying {fmt_err, [imm_err], addr, inst}. Packing logic stays in the top.

Test Plan:
- add x3,x1,x2 (fmt R, opcode 7'h33, rd 3, rs1 1, rs2 2, f3 0, f7 0) after reset, out_ready=1 -> inst=32'h002081B3, addr=0, out_valid one cycle after acceptance.
- addi x5,x0,-1 (fmt I, 7'h13, imm 32'hFFFF_FFFF) then beq x1,x2,+8 (fmt B, 7'h63, imm 8) -> 32'hFFF00293 at addr 0, 32'h00208463 at addr 4.
- jal x1,+2048 (fmt J, 7'h6F, rd 1, imm 32'h800) -> 32'h001000EF. All-ones fields with fmt R -> 32'hFFFFFFFF; a decoder round-trip returns the original fields.
- out_ready=0, push 3 bundles -> in_ready drops after 2 accepts. Raise out_ready -> three words emerge in order at addr 0,4,8. Simultaneous push/pop at count 2 keeps in_ready=1.
- fmt=6 -> inst=0, fmt_err=1, addr still advances by 4. Reset asserted with 2 words queued -> out_valid=0 and next word tagged BASE_ADDR.
- With INST_ENCODER_IMM_CHECK_EN: fmt I with imm 32'h800 -> imm_err=1; imm 32'hFFFF_F800 -> imm_err=0; fmt B with imm 3 -> imm_err=1.
